// File: rtl/pwm_multi_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pwm_multi_gen                                              |
// | Description : Multi-channel PWM generator with clock prescaler, edge- or |
// |               center-aligned counting and shadowed duty registers that   |
// |               are loaded glitch-free at period boundaries.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pwm_multi_gen #(
  parameter int CHANNELS = 4,
  parameter int R        = 6,
  parameter int PRESC_W  = 8
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           enable,
  input  logic [PRESC_W-1:0]                             prescale,
  input  logic                                           mode,
  input  logic                                           wr_en,
  input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] wr_ch,
  input  logic [R:0]                                     wr_duty,
  output logic [CHANNELS-1:0]                            pwm_out,
  output logic                                           period_tick
);

  localparam int            CH_W      = $clog2(CHANNELS > 1 ? CHANNELS : 2);
  localparam logic [R-1:0]  CNT_TOP   = {R{1'b1}};
  localparam logic [R:0]    DUTY_FULL = {1'b1, {R{1'b0}}};
  localparam logic [CH_W:0] NUM_CH    = (CH_W + 1)'(CHANNELS);

  logic [PRESC_W-1:0] pcnt;
  logic [PRESC_W-1:0] presc_l;
  logic [R-1:0]       cnt;
  logic [R-1:0]       cnt_next;
  logic               dir_down;
  logic               dir_down_next;
  logic               mode_l;
  // Set while stopped (reset or enable low); the first enabled cycle is
  // spent loading the shadow registers so the new period starts clean.
  logic               start;
  // Marks the first cycle with cnt==0 of a period; delayed once more to
  // line period_tick up with the registered outputs.
  logic               new_period;
  logic               step;
  logic               boundary;
  logic               load;
  logic [R:0]         wr_sat;
  logic [R:0]         pending [CHANNELS];
  logic [R:0]         active  [CHANNELS];

  // Prescaler terminal count, period boundary detection and write saturation
  always_comb begin
    step     = (pcnt == presc_l);
    boundary = enable & ~start & step & (cnt_next == '0);
    load     = enable & (start | boundary);
    wr_sat   = (wr_duty > DUTY_FULL) ? DUTY_FULL : wr_duty;
  end

  // Next counter value: sawtooth in edge mode, up/down triangle in center mode
  always_comb begin
    cnt_next      = cnt + 1'b1;
    dir_down_next = dir_down;
    if (mode_l) begin
      if (dir_down) begin
        cnt_next = cnt - 1'b1;
      end else if (cnt == CNT_TOP) begin
        cnt_next      = cnt - 1'b1;
        dir_down_next = 1'b1;
      end
    end
  end

  // Prescaler, counter, direction, latched configuration and period marker
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt        <= '0;
      cnt         <= '0;
      dir_down    <= 1'b0;
      mode_l      <= 1'b0;
      presc_l     <= '0;
      start       <= 1'b1;
      new_period  <= 1'b0;
      period_tick <= 1'b0;
    end else if (!enable) begin
      pcnt        <= '0;
      cnt         <= '0;
      dir_down    <= 1'b0;
      start       <= 1'b1;
      new_period  <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= new_period;
      new_period  <= load;
      if (start) begin
        start    <= 1'b0;
        pcnt     <= '0;
        cnt      <= '0;
        dir_down <= 1'b0;
      end else if (step) begin
        pcnt     <= '0;
        cnt      <= cnt_next;
        // Arriving at zero always restarts counting upwards
        dir_down <= boundary ? 1'b0 : dir_down_next;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
      if (load) begin
        mode_l  <= mode;
        presc_l <= prescale;
      end
    end
  end

  // Shadow duty writes and boundary transfer into the live compare registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      if (load) begin
        for (int i = 0; i < CHANNELS; i++) begin
          active[i] <= pending[i];
        end
      end
      if (wr_en && ({1'b0, wr_ch} < NUM_CH)) begin
        pending[wr_ch] <= wr_sat;
      end
    end
  end

  // Registered compare; held low while stopped or during the load cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= enable & ~start & ({1'b0, cnt} < active[i]);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pwm_multi_gen                                           |
// | Description : Directed self-checking bench for pwm_multi_gen.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pwm_multi_gen;

  localparam int CH   = 4;
  localparam int R    = 6;
  localparam int PW   = 8;
  localparam int MAXC = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [PW-1:0] prescale;
  logic          mode;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [R:0]    wr_duty;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
  logic [CH-1:0] prev_pwm;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_multi_gen #(.CHANNELS(CH), .R(R), .PRESC_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .prescale   (prescale),
    .mode       (mode),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_duty    (wr_duty),
    .pwm_out    (pwm_out),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock; samples are taken 1 ns after the rising edge
  task automatic tick();
    prev_pwm = pwm_out;
    @(posedge clk);
    #1;
  endtask

  task automatic write_duty(input int ch, input int val);
    wr_en   = 1'b1;
    wr_ch   = ch[1:0];
    wr_duty = val[R:0];
    tick();
    wr_en   = 1'b0;
  endtask

  // Advance at least one cycle, then stop on the next period_tick
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < MAXC; n++) begin
      tick();
      if (period_tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Starting on a period_tick sample, count cycles and high cycles per
  // channel until the next period_tick. Optional action at cycle act_at:
  // kind 1 = set mode, 2 = write ch0 duty, 3 = set prescale.
  task automatic measure(input int act_at, input int kind, input int val,
                         output int len, output int hi [CH], output bit ok);
    len = 0;
    ok  = 1'b0;
    for (int c = 0; c < CH; c++) hi[c] = 0;
    for (int n = 0; n < MAXC; n++) begin
      if (n > 0 && period_tick) begin
        ok = 1'b1;
        break;
      end
      for (int c = 0; c < CH; c++) hi[c] += int'(pwm_out[c]);
      len++;
      wr_en = 1'b0;
      if (n == act_at) begin
        case (kind)
          1: mode = val[0];
          2: begin wr_en = 1'b1; wr_ch = 2'd0; wr_duty = val[R:0]; end
          3: prescale = val[PW-1:0];
          default: ;
        endcase
      end
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int len;
    int hi [CH];
    bit ok;
    reset = 1'b1; enable = 1'b1; mode = 1'b0; prescale = '0;
    wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
    repeat (3) tick();
    n_checks++; if (pwm_out !== 4'b0000) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out); end
    n_checks++; if (period_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", period_tick); end
    reset = 1'b0;
    tick();
    n_checks++; if (period_tick !== 1'b0) begin n_fail++; $display("FAIL release_load_tick: got %b expected 0", period_tick); end
    tick();
    n_checks++; if (period_tick !== 1'b1) begin n_fail++; $display("FAIL release_first_tick: got %b expected 1", period_tick); end
    measure(-1, 0, 0, len, hi, ok);
    n_checks++; if (!ok || len !== 64) begin n_fail++; $display("FAIL reset_period: got %0d ok=%0d expected 64", len, ok); end
    for (int c = 0; c < CH; c++) begin
      n_checks++; if (hi[c] !== 0) begin n_fail++; $display("FAIL reset_high ch%0d: got %0d expected 0", c, hi[c]); end
    end
  endtask

  task automatic test_enable();
    int len;
    int hi [CH];
    bit ok;
    enable = 1'b0;
    tick();
    tick();
    n_checks++; if (pwm_out !== 4'b0000 || period_tick !== 1'b0) begin n_fail++; $display("FAIL disabled_out: got pwm=%b tick=%b expected 0000/0", pwm_out, period_tick); end
    write_duty(1, 8);
    enable = 1'b1;
    tick();
    tick();
    n_checks++; if (period_tick !== 1'b1) begin n_fail++; $display("FAIL enable_first_tick: got %b expected 1", period_tick); end
    measure(-1, 0, 0, len, hi, ok);
    n_checks++; if (!ok || len !== 64) begin n_fail++; $display("FAIL enable_period: got %0d expected 64", len); end
    n_checks++; if (hi[1] !== 8) begin n_fail++; $display("FAIL enable_pending_write: got %0d expected 8", hi[1]); end
  endtask

  task automatic test_edge();
    int len;
    int hi [CH];
    bit ok, ok2;
    write_duty(0, 16);
    write_duty(1, 48);
    wait_tick(ok);
    wait_tick(ok2);
    n_checks++; if (!ok || !ok2) begin n_fail++; $display("FAIL edge_wait: got timeout expected period_tick"); end
    n_checks++; if (prev_pwm[1:0] !== 2'b00 || pwm_out[1:0] !== 2'b11) begin n_fail++; $display("FAIL edge_rise_at_tick: got prev=%b now=%b expected 00/11", prev_pwm[1:0], pwm_out[1:0]); end
    measure(-1, 0, 0, len, hi, ok);
    n_checks++; if (!ok || len !== 64) begin n_fail++; $display("FAIL edge_period: got %0d expected 64", len); end
    n_checks++; if (hi[0] !== 16) begin n_fail++; $display("FAIL edge_ch0_high: got %0d expected 16", hi[0]); end
    n_checks++; if (hi[1] !== 48) begin n_fail++; $display("FAIL edge_ch1_high: got %0d expected 48", hi[1]); end
  endtask

  task automatic test_saturate_and_center();
    int len;
    int hi [CH];
    bit ok, ok2;
    write_duty(2, 0);
    write_duty(3, 100);
    wait_tick(ok);
    wait_tick(ok2);
    n_checks++; if (!ok || !ok2) begin n_fail++; $display("FAIL sat_wait: got timeout expected period_tick"); end
    for (int k = 0; k < 3; k++) begin
      measure(-1, 0, 0, len, hi, ok);
      n_checks++; if (!ok || len !== 64) begin n_fail++; $display("FAIL sat_edge_period %0d: got %0d expected 64", k, len); end
      n_checks++; if (hi[2] !== 0 || hi[3] !== 64) begin n_fail++; $display("FAIL sat_edge_levels %0d: got ch2=%0d ch3=%0d expected 0/64", k, hi[2], hi[3]); end
    end
    mode = 1'b1;
    wait_tick(ok);
    wait_tick(ok2);
    n_checks++; if (!ok || !ok2) begin n_fail++; $display("FAIL center_wait: got timeout expected period_tick"); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (pwm_out[0] !== 1'b1 || prev_pwm[0] !== 1'b1) begin n_fail++; $display("FAIL center_contiguous %0d: got prev=%b now=%b expected 1/1", k, prev_pwm[0], pwm_out[0]); end
      measure(-1, 0, 0, len, hi, ok);
      n_checks++; if (!ok || len !== 126) begin n_fail++; $display("FAIL center_period %0d: got %0d expected 126", k, len); end
      n_checks++; if (hi[0] !== 31 || hi[1] !== 95) begin n_fail++; $display("FAIL center_high %0d: got ch0=%0d ch1=%0d expected 31/95", k, hi[0], hi[1]); end
      n_checks++; if (hi[2] !== 0 || hi[3] !== 126) begin n_fail++; $display("FAIL sat_center_levels %0d: got ch2=%0d ch3=%0d expected 0/126", k, hi[2], hi[3]); end
    end
  endtask

  task automatic test_mode_change();
    int len;
    int hi [CH];
    bit ok;
    measure(20, 1, 0, len, hi, ok);
    n_checks++; if (!ok || len !== 126 || hi[0] !== 31) begin n_fail++; $display("FAIL mode_change_deferred: got len=%0d ch0=%0d expected 126/31", len, hi[0]); end
    measure(-1, 0, 0, len, hi, ok);
    n_checks++; if (!ok || len !== 64 || hi[0] !== 16) begin n_fail++; $display("FAIL mode_change_applied: got len=%0d ch0=%0d expected 64/16", len, hi[0]); end
  endtask

  task automatic test_shadow();
    int len;
    int hi [CH];
    bit ok;
    measure(10, 2, 32, len, hi, ok);
    n_checks++; if (!ok || hi[0] !== 16) begin n_fail++; $display("FAIL shadow_current: got %0d expected 16", hi[0]); end
    measure(-1, 0, 0, len, hi, ok);
    n_checks++; if (!ok || hi[0] !== 32) begin n_fail++; $display("FAIL shadow_next: got %0d expected 32", hi[0]); end
    // Cycle 62 is the last sample before the edge that loads the boundary
    measure(62, 2, 8, len, hi, ok);
    n_checks++; if (!ok || hi[0] !== 32) begin n_fail++; $display("FAIL boundary_write_current: got %0d expected 32", hi[0]); end
    measure(-1, 0, 0, len, hi, ok);
    n_checks++; if (!ok || hi[0] !== 32) begin n_fail++; $display("FAIL boundary_write_deferred: got %0d expected 32", hi[0]); end
    measure(-1, 0, 0, len, hi, ok);
    n_checks++; if (!ok || hi[0] !== 8) begin n_fail++; $display("FAIL boundary_write_applied: got %0d expected 8", hi[0]); end
    measure(0, 2, 16, len, hi, ok);
    n_checks++; if (!ok || hi[0] !== 8) begin n_fail++; $display("FAIL tick_write_current: got %0d expected 8", hi[0]); end
    measure(-1, 0, 0, len, hi, ok);
    n_checks++; if (!ok || hi[0] !== 16) begin n_fail++; $display("FAIL tick_write_applied: got %0d expected 16", hi[0]); end
  endtask

  task automatic test_prescale_and_reset();
    int len;
    int hi [CH];
    bit ok;
    measure(5, 3, 3, len, hi, ok);
    n_checks++; if (!ok || len !== 64) begin n_fail++; $display("FAIL presc_deferred: got %0d expected 64", len); end
    measure(-1, 0, 0, len, hi, ok);
    n_checks++; if (!ok || len !== 256) begin n_fail++; $display("FAIL presc_period: got %0d expected 256", len); end
    n_checks++; if (hi[0] !== 64 || hi[1] !== 192 || hi[3] !== 256) begin n_fail++; $display("FAIL presc_high: got %0d/%0d/%0d expected 64/192/256", hi[0], hi[1], hi[3]); end
    repeat (50) tick();
    n_checks++; if (pwm_out !== 4'b1011) begin n_fail++; $display("FAIL presc_midperiod: got %b expected 1011", pwm_out); end
    reset    = 1'b1;
    prescale = '0;
    tick();
    n_checks++; if (pwm_out !== 4'b0000 || period_tick !== 1'b0) begin n_fail++; $display("FAIL midreset_out: got pwm=%b tick=%b expected 0000/0", pwm_out, period_tick); end
    tick();
    reset = 1'b0;
    tick();
    tick();
    n_checks++; if (period_tick !== 1'b1) begin n_fail++; $display("FAIL midreset_restart_tick: got %b expected 1", period_tick); end
    measure(-1, 0, 0, len, hi, ok);
    n_checks++; if (!ok || len !== 64) begin n_fail++; $display("FAIL midreset_period: got %0d expected 64", len); end
    for (int c = 0; c < CH; c++) begin
      n_checks++; if (hi[c] !== 0) begin n_fail++; $display("FAIL midreset_cleared ch%0d: got %0d expected 0", c, hi[c]); end
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_edge();
    test_saturate_and_center();
    test_mode_change();
    test_shadow();
    test_prescale_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
